// File: rtl/transpose_hbm_wr_sched_if.sv
// Descriptor handshake between the weight-packing scheduler and the HBM AXI write engine.
interface transpose_hbm_wr_sched_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              cmd_is_scale;
  logic              cmd_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_is_scale, cmd_last,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_is_scale, cmd_last,
    output cmd_ready
  );
endinterface

// File: rtl/transpose_hbm_wr_sched.sv
// HBM write-descriptor scheduler for transposed INT4 weight rows (weight bursts + FP-scale beat per group).
// Optional macro TRANSPOSE_SCALE_FIRST_EN: issue each group's scale beat ahead of its weight bursts.
module transpose_hbm_wr_sched #(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int BEAT_BYTES = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_row_stride,
  input  logic [CNT_W-1:0]  cfg_rows,
  input  logic [CNT_W-1:0]  cfg_groups,
  input  logic [CNT_W-1:0]  cfg_grp_wt_beats,
  input  logic [CNT_W-1:0]  cfg_last_wt_beats,
  output logic              busy,
  output logic              done,
  transpose_hbm_wr_sched_if.master cmd
);

`ifdef TRANSPOSE_SCALE_FIRST_EN
  localparam bit SCALE_FIRST = 1'b1;
`else
  localparam bit SCALE_FIRST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WT, SCALE, ADV, FIN} state_t;

  state_t            state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]        cmd_len_q, cmd_len_d;
  logic              cmd_is_scale_q, cmd_is_scale_d;
  logic              cmd_last_q, cmd_last_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  rows_q, rows_d;
  logic [CNT_W-1:0]  groups_q, groups_d;
  logic [CNT_W-1:0]  grp_beats_q, grp_beats_d;
  logic [CNT_W-1:0]  last_beats_q, last_beats_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  grp_q, grp_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  logic              hs, load, last_pos;
  state_t            nxt;
  logic [CNT_W-1:0]  beats, blen;
  logic [CNT_W-1:0]  rows_e, groups_e, gb_e, lb_e;

  function automatic logic [CNT_W-1:0] group_beats(
    input logic [CNT_W-1:0] g, groups, gb, lb
  );
    return ((g == groups - CNT_W'(1)) && (lb != '0)) ? lb : gb;
  endfunction

  function automatic state_t group_entry(input logic [CNT_W-1:0] wt_beats);
    return (SCALE_FIRST || (wt_beats == '0)) ? SCALE : WT;
  endfunction

  assign hs       = cmd_valid_q & cmd.cmd_ready;
  assign busy     = (state_q == WT) || (state_q == SCALE);
  assign done     = (state_q == FIN);
  assign rows_e   = (state_q == IDLE) ? cfg_rows          : rows_q;
  assign groups_e = (state_q == IDLE) ? cfg_groups        : groups_q;
  assign gb_e     = (state_q == IDLE) ? cfg_grp_wt_beats  : grp_beats_q;
  assign lb_e     = (state_q == IDLE) ? cfg_last_wt_beats : last_beats_q;

  always_comb begin
    nxt            = state_q;
    load           = 1'b0;
    beats          = CNT_W'(cmd_len_q) + CNT_W'(1);
    cmd_valid_d    = cmd_valid_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_len_d      = cmd_len_q;
    cmd_is_scale_d = cmd_is_scale_q;
    cmd_last_d     = cmd_last_q;
    row_base_d     = row_base_q;
    stride_d       = stride_q;
    rows_d         = rows_q;
    groups_d       = groups_q;
    grp_beats_d    = grp_beats_q;
    last_beats_d   = last_beats_q;
    row_d          = row_q;
    grp_d          = grp_q;
    rem_d          = rem_q;

    unique case (state_q)
      IDLE: if (start) begin
        stride_d     = cfg_row_stride;
        rows_d       = cfg_rows;
        groups_d     = cfg_groups;
        grp_beats_d  = cfg_grp_wt_beats;
        last_beats_d = cfg_last_wt_beats;
        if (cfg_rows == '0 || cfg_groups == '0) begin
          nxt = FIN;
        end else begin
          cmd_addr_d = cfg_base_addr;
          row_base_d = cfg_base_addr;
          row_d      = '0;
          grp_d      = '0;
          rem_d      = group_beats('0, cfg_groups, cfg_grp_wt_beats, cfg_last_wt_beats);
          nxt        = group_entry(rem_d);
          load       = 1'b1;
        end
      end
      WT: if (hs) begin
        cmd_addr_d = cmd_addr_q + ADDR_W'(beats) * ADDR_W'(BEAT_BYTES);
        rem_d      = rem_q - beats;
        load       = 1'b1;
        nxt        = (rem_d != '0) ? WT : (SCALE_FIRST ? ADV : SCALE);
      end
      SCALE: if (hs) begin
        cmd_addr_d = cmd_addr_q + ADDR_W'(BEAT_BYTES);
        load       = 1'b1;
        nxt        = (SCALE_FIRST && rem_q != '0) ? WT : ADV;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase

    // ADV is resolved in the same cycle as the handshake so the next group's descriptor follows back-to-back.
    if (nxt == ADV) begin
      if (grp_q == groups_q - CNT_W'(1)) begin
        if (row_q == rows_q - CNT_W'(1)) begin
          nxt = FIN;
        end else begin
          row_d      = row_q + CNT_W'(1);
          grp_d      = '0;
          row_base_d = row_base_q + stride_q;
          cmd_addr_d = row_base_d;
          rem_d      = group_beats('0, groups_q, grp_beats_q, last_beats_q);
          nxt        = group_entry(rem_d);
        end
      end else begin
        grp_d = grp_q + CNT_W'(1);
        rem_d = group_beats(grp_d, groups_q, grp_beats_q, last_beats_q);
        nxt   = group_entry(rem_d);
      end
    end

    last_pos = (grp_d == groups_e - CNT_W'(1)) && (row_d == rows_e - CNT_W'(1));
    blen     = (rem_d > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : rem_d;

    if (load) begin
      if (nxt == FIN) begin
        cmd_valid_d = 1'b0;
      end else begin
        cmd_valid_d    = 1'b1;
        cmd_is_scale_d = (nxt == SCALE);
        cmd_len_d      = (nxt == WT) ? 8'(blen - CNT_W'(1)) : '0;
        if (SCALE_FIRST)
          cmd_last_d = last_pos && ((nxt == WT) ? (rem_d <= CNT_W'(MAX_BURST)) : (rem_d == '0));
        else
          cmd_last_d = last_pos && (nxt == SCALE);
      end
    end
    state_d = nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cmd_valid_q    <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_len_q      <= '0;
      cmd_is_scale_q <= 1'b0;
      cmd_last_q     <= 1'b0;
      row_base_q     <= '0;
      stride_q       <= '0;
      rows_q         <= '0;
      groups_q       <= '0;
      grp_beats_q    <= '0;
      last_beats_q   <= '0;
      row_q          <= '0;
      grp_q          <= '0;
      rem_q          <= '0;
    end else begin
      state_q        <= state_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_len_q      <= cmd_len_d;
      cmd_is_scale_q <= cmd_is_scale_d;
      cmd_last_q     <= cmd_last_d;
      row_base_q     <= row_base_d;
      stride_q       <= stride_d;
      rows_q         <= rows_d;
      groups_q       <= groups_d;
      grp_beats_q    <= grp_beats_d;
      last_beats_q   <= last_beats_d;
      row_q          <= row_d;
      grp_q          <= grp_d;
      rem_q          <= rem_d;
    end
  end

  assign cmd.cmd_valid    = cmd_valid_q;
  assign cmd.cmd_addr     = cmd_addr_q;
  assign cmd.cmd_len      = cmd_len_q;
  assign cmd.cmd_is_scale = cmd_is_scale_q;
  assign cmd.cmd_last     = cmd_last_q;

endmodule

// File: doc/transpose_hbm_wr_sched.md
Name: transpose_hbm_wr_sched

Overview:
Command scheduler for the TRANSPOSE-to-HBM weight-packing path. It sequences the HBM write descriptors that lay out one HBM port's transposed INT4 weight rows.
- Each row is a run of scale groups.
- Each group is a weight segment followed by one FP-scale beat. The last group may be partial.
- Weight segments are split into bursts of at most MAX_BURST beats.
- Descriptors go to the downstream AXI write engine over a valid/ready handshake.

Parameters:
ADDR_W, 32, byte-address width
CNT_W, 16, width of row/group/beat counters
BEAT_BYTES, 32, bytes per HBM AXI beat (HBM_AXI_DATA_WIDTH/8)
MAX_BURST, 16, maximum beats per issued burst (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches cfg_* and begins sequencing
cfg_base_addr  in  ADDR_W  byte address of row 0 (BEAT_BYTES aligned)
cfg_row_stride  in  ADDR_W  byte distance between row starts
cfg_rows  in  CNT_W  rows for this port (CHout_Padding/HBM_Port)
cfg_groups  in  CNT_W  scale groups per row (WT_scale_group_nums)
cfg_grp_wt_beats  in  CNT_W  weight beats in a full group
cfg_last_wt_beats  in  CNT_W  weight beats in final group (0 = same as full)
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after the final handshake
cmd_valid  out  1  descriptor valid
cmd_ready  in  1  downstream accepts descriptor
cmd_addr  out  ADDR_W  burst start byte address
cmd_len  out  8  beats minus 1
cmd_is_scale  out  1  1 = scale beat, 0 = weight burst
cmd_last  out  1  final descriptor of the whole job

Behaviour:
- Reset: busy=0, done=0, cmd_valid=0, cmd_addr=0, cmd_len=0, cmd_is_scale=0, cmd_last=0, FSM=IDLE. rst overrides everything, including mid-job. No descriptor survives reset.
- Config is sampled only on an accepted start (IDLE). start while busy is ignored.
- FSM states: IDLE, WT, SCALE, ADV, FIN.
- IDLE → start:
  - If cfg_rows==0 or cfg_groups==0, go to FIN: done pulses next cycle, no descriptors are issued.
  - Otherwise go to WT. The first cmd_valid is asserted the cycle after start.
- WT:
  - Issues bursts of min(remaining, MAX_BURST) beats at the current address.
  - On each handshake: addr += beats*BEAT_BYTES; remaining -= beats.
  - When remaining reaches 0, go to SCALE.
  - If the group's weight beat count is 0, WT is skipped.
- SCALE:
  - Issues one descriptor with cmd_len=0, cmd_is_scale=1 at the current address.
  - On handshake: addr += BEAT_BYTES, then go to ADV.
- ADV (zero-cost):
  - Next group: increment the group counter. The final group uses cfg_last_wt_beats if nonzero, else cfg_grp_wt_beats.
  - Row wrap: when the group counter wraps, row_base += cfg_row_stride and addr = row_base.
  - After the final row: go to FIN.
  - Next cmd_valid may assert in the cycle after the handshake. At most one bubble per descriptor; full-throughput (back-to-back) is preferred.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Handshake rules:
  - cmd_* are registered.
  - While cmd_valid && !cmd_ready, all cmd_* are held stable.
  - cmd_valid is never dropped without a handshake.
- cmd_last=1 only on the last scale descriptor of the last row.
- Address arithmetic is modulo 2^ADDR_W (wrap, no error). Counters are CNT_W wide, with no saturation.
- cmd_len width is 8. MAX_BURST ≤ 256 is required.

Optional Feature:
TRANSPOSE_SCALE_FIRST_EN
- Defined: within each group, the SCALE descriptor is issued before that group's weight bursts. The scale beat occupies the group's first BEAT_BYTES. cmd_last moves to the final weight burst of the last group. If that group has 0 weight beats, cmd_last moves to its scale beat.
- Undefined: weights first, scale last, as described above.

Test Plan:
1. Common config: base=0x0, stride=0x500, rows=2, groups=2, grp_wt_beats=32, last_wt_beats=3, MAX_BURST=16, cmd_ready=1. Response: 10 descriptors, row 0 is (0x000,15,W) (0x200,15,W) (0x400,0,S) (0x420,2,W) (0x480,0,S). Row 1 is the same offsets +0x500. cmd_last only on (0x980,S). done pulses exactly once, the cycle after that handshake.
2. Same config, cmd_ready toggling randomly 30% low → identical descriptor sequence. cmd_* stable across every stall cycle.
3. groups=0 or rows=0 → no cmd_valid. done pulses the cycle after start+1. busy lasts ≤1 cycle.
4. Assert start again mid-job → ignored, sequence unchanged. Assert rst at the 4th descriptor → next cycle cmd_valid=0, busy=0. A following start restarts from base with a clean sequence.
5. last_wt_beats=0, groups=1, grp_wt_beats=40 → bursts of 16, 16, 8 at 0x000/0x200/0x400, then scale at 0x500.
6. Build with TRANSPOSE_SCALE_FIRST_EN, Test 1 config → row 0 is (0x000,S) (0x020,15,W) (0x220,15,W) (0x420,S) (0x440,2,W). cmd_last is on row 1 (0x940,2,W).
